rx_sm: RTL

Receive-side controller for the synchronous TX-RX link. It sits directly downstream of the transmit state machine. It advertises readiness on `rx_ready` and deserialises LSB-first bits sampled while `tx_valid` is high, storing each completed byte in a small buffer. When the buffer holds a full frame it raises `rx_done`, which releases the transmitter from its finish state. A local consumer reads the buffer and acknowledges with `clear`.

---
 rtl/txrx_pkg.sv | 19 +
 rtl/rx_sm_if.sv | 56 +++++
 rtl/rx_byte_buf.sv | 46 ++++
 rtl/rx_sm.sv | 139 +++++++++++++
 4 files changed

// File: rtl/txrx_pkg.sv
// Shared definitions for the synchronous TX-RX link.
// Contents:
//   TXRX_DATA_W  default bits per byte
//   TXRX_DEPTH   default bytes per frame (power of two, >= 2)
//   rx_state_e   receive controller state encoding
package txrx_pkg;

    localparam int unsigned TXRX_DATA_W = 8;
    localparam int unsigned TXRX_DEPTH  = 4;

    typedef enum logic [2:0] {
        RDY      = 3'd0,
        SHIFT    = 3'd1,
        STORE    = 3'd2,
        WAIT_LOW = 3'd3,
        FULL     = 3'd4
    } rx_state_e;

endpackage

// File: rtl/rx_sm_if.sv
// Link/consumer bundle between the transmitter + local consumer and rx_sm.
// Signals:
//   tx_valid, tx_data   serial bit qualifier and LSB-first data bit
//   rx_ready            receiver can accept a new byte
//   byte_wr             one-cycle pulse per stored byte
//   wr_addr             next buffer slot to be written
//   rx_done             frame complete, held until clear
//   rd_addr, rd_data    consumer read port (combinational read)
//   clear               consumer acknowledge of a full frame
// Modports:
//   master  transmitter/consumer side
//   slave   receiver (rx_sm) side
interface rx_sm_if
    import txrx_pkg::*;
#(
    parameter int unsigned DATA_W = TXRX_DATA_W,
    parameter int unsigned DEPTH  = TXRX_DEPTH
) ();

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic              tx_valid;
    logic              tx_data;
    logic              rx_ready;
    logic              byte_wr;
    logic [ADDR_W-1:0] wr_addr;
    logic              rx_done;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              clear;

    modport master (
        output tx_valid,
        output tx_data,
        output rd_addr,
        output clear,
        input  rx_ready,
        input  byte_wr,
        input  wr_addr,
        input  rx_done,
        input  rd_data
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        input  rd_addr,
        input  clear,
        output rx_ready,
        output byte_wr,
        output wr_addr,
        output rx_done,
        output rd_data
    );

endinterface

// File: rtl/rx_byte_buf.sv
// DEPTH x DATA_W register file holding one received frame.
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset (clears all slots)
//   we         write enable
//   waddr      write slot
//   wdata      write byte
//   raddr      read slot
//   rdata      buffer[raddr], combinational; returns old contents during a write
module rx_byte_buf
    import txrx_pkg::*;
#(
    parameter int unsigned DATA_W = TXRX_DATA_W,
    parameter int unsigned DEPTH  = TXRX_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Next contents: single-slot update on write.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/rx_sm.sv
// Receive-side controller of the synchronous TX-RX link.
// Deserialises LSB-first bits qualified by tx_valid, stores each byte in a
// DEPTH-entry buffer and raises rx_done once a whole frame is held. The
// consumer reads the buffer and acknowledges with clear.
// Ports:
//   clk   rising-edge system clock
//   rst   synchronous active-high reset
//   bus   rx_sm_if.slave: tx_valid/tx_data in, rx_ready/byte_wr/wr_addr/rx_done
//         out, rd_addr/clear in, rd_data out (combinational)
module rx_sm
    import txrx_pkg::*;
#(
    parameter int unsigned DATA_W = TXRX_DATA_W,
    parameter int unsigned DEPTH  = TXRX_DEPTH
) (
    input  logic    clk,
    input  logic    rst,
    rx_sm_if.slave  bus
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DATA_W) + 1;

    rx_state_e         state_q,    state_d;
    logic [DATA_W-1:0] shreg_q,    shreg_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
    logic              rx_ready_q, rx_ready_d;
    logic              byte_wr_q,  byte_wr_d;
    logic              rx_done_q,  rx_done_d;

    logic              buf_we;
    logic [DATA_W-1:0] shifted;
    logic              last_bit;

    // New bit enters at the MSB so that after DATA_W shifts bit 0 sits at the LSB.
    assign shifted  = {bus.tx_data, shreg_q[DATA_W-1:1]};
    assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        wr_addr_d = wr_addr_q;
        buf_we    = 1'b0;

        case (state_q)
            RDY: begin
                if (bus.tx_valid) begin
                    shreg_d = shifted;
                    cnt_d   = CNT_W'(1);
                    state_d = (DATA_W == 1) ? STORE : SHIFT;
                end
            end

            SHIFT: begin
                // tx_valid low is a gap: everything holds.
                if (bus.tx_valid) begin
                    shreg_d = shifted;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        state_d = STORE;
                    end
                end
            end

            STORE: begin
                // Input is ignored here; this absorbs the transmitter's trailing beat.
                buf_we    = 1'b1;
                wr_addr_d = wr_addr_q + ADDR_W'(1);
                cnt_d     = '0;
                state_d   = WAIT_LOW;
            end

            WAIT_LOW: begin
                // wr_addr has already wrapped to 0 iff the stored slot was DEPTH-1.
                if (!bus.tx_valid) begin
                    state_d = (wr_addr_q == '0) ? FULL : RDY;
                end
            end

            FULL: begin
                if (bus.clear) begin
                    wr_addr_d = '0;
                    state_d   = RDY;
                end
            end

            default: begin
                state_d = RDY;
            end
        endcase

        rx_ready_d = (state_d == RDY);
        byte_wr_d  = (state_d == STORE);
        rx_done_d  = (state_d == FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RDY;
            shreg_q    <= '0;
            cnt_q      <= '0;
            wr_addr_q  <= '0;
            rx_ready_q <= 1'b1;
            byte_wr_q  <= 1'b0;
            rx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            wr_addr_q  <= wr_addr_d;
            rx_ready_q <= rx_ready_d;
            byte_wr_q  <= byte_wr_d;
            rx_done_q  <= rx_done_d;
        end
    end

    rx_byte_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (buf_we),
        .waddr (wr_addr_q),
        .wdata (shreg_q),
        .raddr (bus.rd_addr),
        .rdata (bus.rd_data)
    );

    assign bus.rx_ready = rx_ready_q;
    assign bus.byte_wr  = byte_wr_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.rx_done  = rx_done_q;

endmodule
